// File: rtl/seq_detector_param.sv
// Serial pattern detector with a runtime-loadable pattern, pattern length and
// overlap mode. The newest accepted bit sits at pat[0]. Every match gives a
// one-cycle registered pulse and bumps a saturating match counter.
module seq_detector_param #(
  parameter int PAT_W = 8,
  parameter int CNT_W = 16,
  localparam int LEN_W = $clog2(PAT_W + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  input  logic             din_valid,
  input  logic             cfg_load,
  input  logic [PAT_W-1:0] pat,
  input  logic [LEN_W-1:0] pat_len,
  input  logic             overlap,
  input  logic             clr_cnt,
  output logic             match,
  output logic [CNT_W-1:0] match_cnt,
  output logic             armed,
  output logic             cfg_err
);

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    HUNT
  } state_t;

  state_t             state;
  logic [PAT_W-1:0]   hist;
  logic [LEN_W-1:0]   fill;
  logic [PAT_W-1:0]   pat_q;
  logic [LEN_W-1:0]   len_q;
  logic               ovl_q;

  logic [PAT_W-1:0]   mask;
  logic [PAT_W-1:0]   window;
  logic [LEN_W-1:0]   fill_inc;
  logic               cfg_ok;
  logic               accept;
  logic               hit;

  // Window compare: only the low len_q bits of pattern and history take part.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    mask = '0;
    for (int i = 0; i < PAT_W; i++) begin
      mask[i] = (LEN_W'(i) < len_q);
    end
    window   = {hist[PAT_W-2:0], din};
    fill_inc = (fill == LEN_W'(PAT_W)) ? fill : fill + LEN_W'(1);
    cfg_ok   = (pat_len != '0) && (pat_len <= LEN_W'(PAT_W));
    // A concurrent cfg_load discards the bit, and IDLE ignores input.
    accept   = din_valid && !cfg_load && (state != IDLE);
    hit      = accept && (((window ^ pat_q) & mask) == '0) && (fill_inc >= len_q);
  end

  // Control FSM: configuration, history shifting, match pulse and error pulse.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      hist    <= '0;
      fill    <= '0;
      pat_q   <= '0;
      len_q   <= '0;
      ovl_q   <= 1'b0;
      match   <= 1'b0;
      armed   <= 1'b0;
      cfg_err <= 1'b0;
    end else begin
      match   <= 1'b0;
      cfg_err <= 1'b0;
      if (cfg_load) begin
        if (cfg_ok) begin
          pat_q <= pat;
          len_q <= pat_len;
          ovl_q <= overlap;
          hist  <= '0;
          fill  <= '0;
          state <= FILL;
          armed <= 1'b1;
        end else begin
          cfg_err <= 1'b1;
          state   <= IDLE;
          armed   <= 1'b0;
        end
      end else if (accept) begin
        if (hit) begin
          match <= 1'b1;
          if (ovl_q) begin
            hist  <= window;
            fill  <= fill_inc;
            state <= HUNT;
          end else begin
            // Non-overlapping: the next match must be built from fresh bits.
            hist  <= '0;
            fill  <= '0;
            state <= FILL;
          end
        end else begin
          hist  <= window;
          fill  <= fill_inc;
          state <= (fill_inc >= len_q) ? HUNT : FILL;
        end
      end
    end
  end

  // Saturating match counter; a synchronous clear beats a coincident match.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      match_cnt <= '0;
    end else if (clr_cnt) begin
      match_cnt <= '0;
    end else if (hit && (match_cnt != '1)) begin
      match_cnt <= match_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_seq_detector_param.sv
// Directed bench for seq_detector_param. Two instances share every input: one
// with default parameters and one with a 2-bit counter to exercise saturation.
module tb_seq_detector_param;

  logic       clk;
  logic       rst;
  logic       din;
  logic       din_valid;
  logic       cfg_load;
  logic [7:0] pat;
  logic [3:0] pat_len;
  logic       overlap;
  logic       clr_cnt;

  logic        match,   s_match;
  logic [15:0] match_cnt;
  logic [1:0]  s_cnt;
  logic        armed,   s_armed;
  logic        cfg_err, s_err;

  int vecs;
  int miscompares;

  seq_detector_param dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
    .cfg_load(cfg_load), .pat(pat), .pat_len(pat_len), .overlap(overlap),
    .clr_cnt(clr_cnt), .match(match), .match_cnt(match_cnt),
    .armed(armed), .cfg_err(cfg_err)
  );

  seq_detector_param #(.PAT_W(8), .CNT_W(2)) dut_s (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
    .cfg_load(cfg_load), .pat(pat), .pat_len(pat_len), .overlap(overlap),
    .clr_cnt(clr_cnt), .match(s_match), .match_cnt(s_cnt),
    .armed(s_armed), .cfg_err(s_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Drive one cycle of inputs on the falling edge; return 1ns after the rising edge.
  task automatic tick(input logic c, input logic dv, input logic d, input logic clr);
    @(negedge clk);
    cfg_load  = c;
    din_valid = dv;
    din       = d;
    clr_cnt   = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input logic [7:0] p, input logic [3:0] l, input logic o);
    pat     = p;
    pat_len = l;
    overlap = o;
    tick(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic send(input string tag, input logic d, input logic exp_match);
    tick(1'b0, 1'b1, d, 1'b0);
    check(tag, 32'(match), 32'(exp_match));
  endtask

  initial begin
    logic [7:0] seq;
    int         hits;
    vecs        = 0;
    miscompares = 0;
    rst = 1'b1; din = 1'b0; din_valid = 1'b0; cfg_load = 1'b0;
    pat = '0; pat_len = '0; overlap = 1'b0; clr_cnt = 1'b0;

    // Reset state
    #12;
    check("rst_match", 32'(match), 0);
    check("rst_cnt", 32'(match_cnt), 0);
    check("rst_armed", 32'(armed), 0);
    check("rst_cfg_err", 32'(cfg_err), 0);
    @(negedge clk);
    rst = 1'b0;

    // IDLE ignores input
    for (int i = 0; i < 4; i++) send("idle_nomatch", 1'b1, 1'b0);
    check("idle_armed", 32'(armed), 0);

    // Run of ones, overlapping
    cfg(8'b111, 4'd3, 1'b1);
    check("ones_armed", 32'(armed), 1);
    check("ones_cfg_err", 32'(cfg_err), 0);
    send("ones_b1", 1'b1, 1'b0);
    send("ones_b2", 1'b1, 1'b0);
    send("ones_b3", 1'b1, 1'b1);
    send("ones_b4", 1'b1, 1'b1);
    send("ones_b5", 1'b0, 1'b0);
    send("ones_b6", 1'b1, 1'b0);
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    check("ones_gap", 32'(match), 0);
    check("ones_cnt", 32'(match_cnt), 2);
    check("ones_cnt_s", 32'(s_cnt), 2);

    tick(1'b0, 1'b0, 1'b0, 1'b1);
    check("clr_cnt", 32'(match_cnt), 0);
    check("clr_cnt_s", 32'(s_cnt), 0);

    // 1010 non-overlapping; upper pattern bits are garbage and must be ignored
    seq = 8'b1010_1010;
    cfg(8'hFA, 4'd4, 1'b0);
    for (int i = 7; i >= 0; i--) send("nonovl", seq[i], (i == 4 || i == 0));
    check("nonovl_cnt", 32'(match_cnt), 2);

    // Same stream overlapping; reconfiguring keeps the count
    cfg(8'hFA, 4'd4, 1'b1);
    check("cfg_keeps_cnt", 32'(match_cnt), 2);
    for (int i = 7; i >= 0; i--) send("ovl", seq[i], (i == 4 || i == 2 || i == 0));
    check("ovl_cnt", 32'(match_cnt), 5);
    check("sat_cnt_s", 32'(s_cnt), 3);

    // Gapped input: din_valid low between accepted bits
    cfg(8'b101, 4'd3, 1'b1);
    send("gap_b1", 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick(1'b0, 1'b0, 1'b1, 1'b0);
      check("gap_hold1", 32'(match), 0);
    end
    send("gap_b2", 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick(1'b0, 1'b0, 1'b1, 1'b0);
      check("gap_hold2", 32'(match), 0);
    end
    send("gap_b3", 1'b1, 1'b1);
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    check("gap_pulse_end", 32'(match), 0);
    check("gap_cnt", 32'(match_cnt), 6);
    check("gap_cnt_s", 32'(s_cnt), 3);

    // cfg_load wins over a coincident valid bit, which is discarded
    pat = 8'b111; pat_len = 4'd3; overlap = 1'b1;
    tick(1'b1, 1'b1, 1'b1, 1'b0);
    send("cfgwin_b1", 1'b1, 1'b0);
    send("cfgwin_b2", 1'b1, 1'b0);
    send("cfgwin_b3", 1'b1, 1'b1);
    check("cfgwin_cnt", 32'(match_cnt), 7);

    // clr_cnt coincident with a match: pulse still emitted, count cleared
    tick(1'b0, 1'b1, 1'b1, 1'b1);
    check("clrhit_match", 32'(match), 1);
    check("clrhit_cnt", 32'(match_cnt), 0);
    check("clrhit_cnt_s", 32'(s_cnt), 0);
    send("after_clr", 1'b1, 1'b1);
    check("after_clr_cnt", 32'(match_cnt), 1);

    // Rejected configurations
    cfg(8'b111, 4'd0, 1'b1);
    check("bad0_err", 32'(cfg_err), 1);
    check("bad0_armed", 32'(armed), 0);
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    check("bad_err_pulse", 32'(cfg_err), 0);
    cfg(8'b111, 4'd9, 1'b1);
    check("bad9_err", 32'(cfg_err), 1);
    check("bad9_armed", 32'(armed), 0);
    hits = 0;
    for (int i = 0; i < 20; i++) begin
      tick(1'b0, 1'b1, 1'b1, 1'b0);
      if (match) hits++;
    end
    check("bad_nomatch", 32'(hits), 0);
    check("bad_cnt", 32'(match_cnt), 1);

    // Full-width pattern
    seq = 8'hA5;
    cfg(8'hA5, 4'd8, 1'b0);
    check("full_armed", 32'(armed), 1);
    for (int i = 7; i >= 0; i--) send("full", seq[i], (i == 0));
    check("full_cnt", 32'(match_cnt), 2);

    // Reset mid-pattern, reconfigure on the first edge after release
    cfg(8'b111, 4'd3, 1'b1);
    send("rstmid_b1", 1'b1, 1'b0);
    send("rstmid_b2", 1'b1, 1'b0);
    #2 rst = 1'b1;
    #1;
    check("rstmid_armed", 32'(armed), 0);
    check("rstmid_cnt", 32'(match_cnt), 0);
    @(negedge clk);
    rst = 1'b0; cfg_load = 1'b1; din_valid = 1'b0; clr_cnt = 1'b0;
    @(posedge clk);
    #1;
    check("rel_first_edge", 32'(armed), 1);
    send("rstmid_n1", 1'b1, 1'b0);
    send("rstmid_n2", 1'b1, 1'b0);
    send("rstmid_n3", 1'b1, 1'b1);
    check("rstmid_cnt2", 32'(match_cnt), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
    $finish;
  end

endmodule
